// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: funct3 branch codes, FSM states,
// the BHT reset value and the 2-bit saturating counter update.
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken
  localparam logic [1:0] BHT_RESET_VAL = 2'b01;

  typedef enum logic {
    StIdle,
    StFlush
  } bru_state_e;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic inc);
    if (inc) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch outcome from funct3 and the ALU flags of rs1-rs2.
// valid is low for funct3 codes that are not branches.
module branch_cond
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zf,
  input  logic       cf,
  input  logic       vf,
  input  logic       sf,
  output logic       taken,
  output logic       valid
);

  always_comb begin
    taken = 1'b0;
    valid = 1'b1;
    case (funct3)
      F3_BEQ:  taken = zf;
      F3_BNE:  taken = ~zf;
      F3_BLT:  taken = (sf != vf);
      F3_BGE:  taken = (sf == vf);
      F3_BLTU: taken = ~cf;
      F3_BGEU: taken = cf;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: 2-bit BHT predictor, outcome evaluation and mispredict flush FSM.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BHT_DEPTH    = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  input  logic            res_valid,
  input  logic [2:0]      res_funct3,
  input  logic            res_zf,
  input  logic            res_cf,
  input  logic            res_vf,
  input  logic            res_sf,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  output logic            taken,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
`endif
);

  localparam int unsigned IdxW    = $clog2(BHT_DEPTH);
  localparam logic [3:0]  CntInit = 4'(FLUSH_CYCLES - 1);

  bru_state_e      state_q;
  logic [3:0]      cnt_q;
  logic [1:0]      bht_q [BHT_DEPTH];
  logic [IdxW-1:0] idx_f;
  logic [IdxW-1:0] idx_r;
  logic            f3_valid;
  logic            accept;
  logic            bht_we;
  logic            mispredict;

  branch_cond u_branch_cond (
    .funct3 (res_funct3),
    .zf     (res_zf),
    .cf     (res_cf),
    .vf     (res_vf),
    .sf     (res_sf),
    .taken  (taken),
    .valid  (f3_valid)
  );

  assign idx_f        = pc_f[IdxW+1:2];
  assign idx_r        = res_pc[IdxW+1:2];
  assign busy         = (state_q == StFlush);
  assign accept       = res_valid & ~busy;
  assign bht_we       = accept & f3_valid;
  assign mispredict   = accept & (taken != res_pred_taken);
  // Read the registered entry: a same-cycle update is not visible to the lookup
  assign pred_taken_f = bht_q[idx_f][1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[XLEN-1:IdxW+2], pc_f[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= BHT_RESET_VAL;
      end
    end else if (bht_we) begin
      bht_q[idx_r] <= sat_update(bht_q[idx_r], taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mispredict) begin
            state_q     <= StFlush;
            cnt_q       <= CntInit;
            flush       <= 1'b1;
            redirect_pc <= taken ? res_target : res_pc + XLEN'(4);
          end
        end
        StFlush: begin
          if (cnt_q == 4'd0) begin
            state_q <= StIdle;
            flush   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          flush   <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count      <= 32'd0;
      mispred_count <= 32'd0;
    end else begin
      if (accept) begin
        br_count <= br_count + 32'd1;
      end
      if (mispredict) begin
        mispred_count <= mispred_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: flush responses go through a scoreboard queue
// popped by a negedge monitor; predictions and outcomes are checked in line.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FC   = 2;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pc_f;
  logic            pred_taken_f;
  logic            res_valid;
  logic [2:0]      res_funct3;
  logic            res_zf, res_cf, res_vf, res_sf;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] res_target;
  logic            res_pred_taken;
  logic            taken;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]     br_count;
  logic [31:0]     mispred_count;
`endif

  branch_resolve_unit #(
    .XLEN         (XLEN),
    .BHT_DEPTH    (16),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_f           (pc_f),
    .pred_taken_f   (pred_taken_f),
    .res_valid      (res_valid),
    .res_funct3     (res_funct3),
    .res_zf         (res_zf),
    .res_cf         (res_cf),
    .res_vf         (res_vf),
    .res_sf         (res_sf),
    .res_pc         (res_pc),
    .res_target     (res_target),
    .res_pred_taken (res_pred_taken),
    .taken          (taken),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
`ifdef BRU_PERF_CNT_EN
    ,
    .br_count       (br_count),
    .mispred_count  (mispred_count)
`endif
  );

  typedef struct {
    logic [31:0] redir;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_br = 0;
  int   exp_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a rising flush pops one expected redirect; the falling edge checks its length
  bit   in_fl = 1'b0;
  int   fl_len = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (flush === 1'b1 && !in_fl) begin
      in_fl  = 1'b1;
      fl_len = 1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        cur.redir = '0;
        cur.len   = 0;
        $display("FAIL unexpected_flush: got flush with redirect 0x%0h, want no flush (t=%0t)",
                 redirect_pc, $time);
      end else begin
        cur = exp_q.pop_front();
        check("redirect_pc", redirect_pc, cur.redir);
      end
    end else if (flush === 1'b1) begin
      fl_len++;
    end else if (in_fl) begin
      in_fl = 1'b0;
      if (cur.len != 0) check("flush_len", fl_len, cur.len);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic exp);
    pc_f = pc;
    #1;
    check(name, pred_taken_f, exp);
  endtask

  task automatic tchk(input logic [2:0] f3, input logic z, c, v, s, input logic exp);
    res_funct3 = f3;
    res_zf = z; res_cf = c; res_vf = v; res_sf = s;
    #1;
    check($sformatf("taken_f3_%0d_zcvs_%b%b%b%b", f3, z, c, v, s), taken, exp);
  endtask

  // len = expected flush length (0: none); acc = resolve expected to be accepted
  task automatic resolve(input logic [2:0] f3, input logic z, c, v, s,
                         input logic [31:0] pc, tgt, input logic pred,
                         input bit acc, input int len, input logic [31:0] redir);
    res_funct3 = f3;
    res_zf = z; res_cf = c; res_vf = v; res_sf = s;
    res_pc = pc; res_target = tgt; res_pred_taken = pred;
    res_valid = 1'b1;
    if (len > 0) exp_q.push_back('{redir: redir, len: len});
    if (acc) exp_br++;
    if (acc && len > 0) exp_mis++;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pc_f = '0;
    res_valid = 1'b0;
    res_funct3 = 3'b010;
    {res_zf, res_cf, res_vf, res_sf} = 4'b0;
    res_pc = '0; res_target = '0; res_pred_taken = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_flush", flush, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_redirect", redirect_pc, 32'h0);
    rst = 1'b0;

    // Every BHT entry weakly not-taken after reset
    for (int i = 0; i < 16; i++) lookup($sformatf("bht_rst_%0d", i), 32'(i * 4), 1'b0);
    lookup("pred_0x40", 32'h40, 1'b0);

    tchk(F3_BEQ,  1, 0, 0, 0, 1);
    tchk(F3_BEQ,  0, 0, 0, 0, 0);
    tchk(F3_BNE,  0, 0, 0, 0, 1);
    tchk(F3_BNE,  1, 0, 0, 0, 0);
    tchk(F3_BLT,  0, 0, 0, 1, 1);
    tchk(F3_BLT,  0, 0, 1, 1, 0);
    tchk(F3_BGE,  0, 0, 1, 1, 1);
    tchk(F3_BGE,  0, 0, 1, 0, 0);
    tchk(F3_BLTU, 0, 0, 0, 0, 1);
    tchk(F3_BLTU, 0, 1, 0, 0, 0);
    tchk(F3_BGEU, 0, 1, 0, 0, 1);
    tchk(3'b010,  1, 1, 1, 1, 0);
    tchk(3'b011,  1, 0, 1, 0, 0);
    idle(1);

    // BEQ taken, predicted not-taken
    resolve(F3_BEQ, 1, 0, 0, 0, 32'h100, 32'h200, 0, 1, FC, 32'h200);
    check("busy_in_flush", busy, 1'b1);
    idle(2);
    check("busy_after_flush", busy, 1'b0);
    lookup("bht0_now_10", 32'h100, 1'b1);

    // BNE not taken, predicted taken; a resolve during flush is ignored
    resolve(F3_BNE, 1, 0, 0, 0, 32'h104, 32'h500, 1, 1, FC, 32'h108);
    resolve(F3_BEQ, 1, 0, 0, 0, 32'h104, 32'h600, 0, 0, 0, 32'h0);
    idle(1);
    lookup("bht1_after_bne", 32'h104, 1'b0);
    resolve(F3_BEQ, 1, 0, 0, 0, 32'h104, 32'h700, 0, 1, FC, 32'h700);
    idle(2);
    lookup("bht1_unchanged_in_flush", 32'h104, 1'b0);

    // Four taken BLTU at one PC; only the first mispredicts
    resolve(F3_BLTU, 0, 0, 0, 0, 32'h208, 32'h900, 0, 1, FC, 32'h900);
    idle(2);
    lookup("bltu_after_1", 32'h208, 1'b1);
    resolve(F3_BLTU, 0, 0, 0, 0, 32'h208, 32'h900, 1, 1, 0, 32'h0);
    resolve(F3_BLTU, 0, 0, 0, 0, 32'h208, 32'h900, 1, 1, 0, 32'h0);
    resolve(F3_BLTU, 0, 0, 0, 0, 32'h208, 32'h900, 1, 1, 0, 32'h0);
    check("no_flush_correct_pred", flush, 1'b0);
    lookup("bltu_after_4", 32'h208, 1'b1);
    // One not-taken from a saturated 11 leaves 10, still predicting taken
    resolve(F3_BGEU, 0, 0, 0, 0, 32'h208, 32'h900, 1, 1, FC, 32'h20c);
    idle(2);
    lookup("bht2_saturated", 32'h208, 1'b1);

    // PC wrap on not-taken, then reset in the second flush cycle
    resolve(F3_BNE, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h1234, 1, 1, 1, 32'h0);
    @(posedge clk);
    #1;
    check("flush_before_rst", flush, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_flush_flush", flush, 1'b0);
    check("rst_mid_flush_busy", busy, 1'b0);
    check("rst_mid_flush_redirect", redirect_pc, 32'h0);
    exp_br = 0;
    exp_mis = 0;
    lookup("bht0_reset_again", 32'h100, 1'b0);
    lookup("bht2_reset_again", 32'h208, 1'b0);

    // First resolve honoured on the first edge after reset release
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resolve(F3_BEQ, 1, 0, 0, 0, 32'h100, 32'h300, 0, 1, FC, 32'h300);
    check("first_after_rst_flush", flush, 1'b1);
    idle(2);
    lookup("bht0_first_after_rst", 32'h100, 1'b1);

    // Invalid funct3: not taken, no BHT update
    resolve(3'b010, 1, 1, 1, 1, 32'h10c, 32'h800, 0, 1, 0, 32'h0);
    check("invalid_f3_no_flush", flush, 1'b0);
    resolve(F3_BEQ, 1, 0, 0, 0, 32'h10c, 32'h880, 0, 1, FC, 32'h880);
    idle(2);
    lookup("bht3_invalid_no_update", 32'h10c, 1'b1);

    resolve(F3_BEQ, 0, 0, 0, 0, 32'h110, 32'h990, 0, 1, 0, 32'h0);
    resolve(F3_BEQ, 0, 0, 0, 0, 32'h110, 32'h990, 0, 1, 0, 32'h0);
    idle(3);

`ifdef BRU_PERF_CNT_EN
    check("br_count", br_count, 32'(exp_br));
    check("mispred_count", mispred_count, 32'(exp_mis));
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("flush_idle_end", flush, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
